// File: rtl/edid_i2c_target.sv
// EDID I2C target: answers one 7-bit address, accepts a single word-address
// byte to set the read pointer, and streams bytes from an external 8-bit ROM.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | bus free or not addressed since reset/STOP
// DEVADDR   | shifting in device address + R/W bit
// ACK_DEV   | driving ACK for our device address
// WORDADDR  | shifting in word address byte
// ACK_WORD  | driving ACK for the word address
// TX_BYTE   | shifting out ROM data, MSB first
// RX_ACK    | released SDA, waiting for master ACK/NACK
// WAIT_STOP | not participating; only START/STOP are honored
module edid_i2c_target #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rom_addr,
    input  logic [7:0] rom_dout,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE, DEVADDR, ACK_DEV, WORDADDR, ACK_WORD, TX_BYTE, RX_ACK, WAIT_STOP
    } state_t;

    state_t                 state, state_nx;
    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_d, sda_d;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det;
    logic [3:0]             bit_cnt, bit_cnt_nx;
    logic [7:0]             shift, shift_nx;
    logic [7:0]             ptr, ptr_nx;
    logic                   sda_oe_nx;
    logic                   rw, rw_nx;
    logic                   tx_load;

    assign scl_s     = scl_sync[SYNC_STAGES-1];
    assign sda_s     = sda_sync[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_d;
    assign scl_fall  = ~scl_s & scl_d;
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;
    assign rom_addr  = ptr;
    assign busy      = (state != IDLE);

    // Pad synchronizers plus one delay stage for edge detection; reset to bus-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= 4'd0;
            shift   <= 8'h00;
            ptr     <= 8'h00;
            sda_oe  <= 1'b0;
            rw      <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_cnt <= bit_cnt_nx;
            shift   <= shift_nx;
            ptr     <= ptr_nx;
            sda_oe  <= sda_oe_nx;
            rw      <= rw_nx;
        end
    end

    // Next-state and datapath update; STOP beats START beats per-state work.
    always_comb begin
        state_nx   = state;
        bit_cnt_nx = bit_cnt;
        shift_nx   = shift;
        ptr_nx     = ptr;
        sda_oe_nx  = sda_oe;
        rw_nx      = rw;
        tx_load    = 1'b0;
        if (stop_det) begin
            state_nx  = IDLE;
            sda_oe_nx = 1'b0;
        end else if (start_det) begin
            state_nx   = DEVADDR;
            bit_cnt_nx = 4'd0;
        end else begin
            case (state)
                IDLE: ;
                DEVADDR, WORDADDR: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_nx   = {shift[6:0], sda_s};
                        bit_cnt_nx = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        bit_cnt_nx = 4'd0;
                        if (state == WORDADDR) begin
                            ptr_nx    = shift;
                            state_nx  = ACK_WORD;
                            sda_oe_nx = 1'b1;
                        end else if (shift[7:1] == DEV_ADDR) begin
                            rw_nx     = shift[0];
                            state_nx  = ACK_DEV;
                            sda_oe_nx = 1'b1;
                        end else begin
                            state_nx  = WAIT_STOP;
                        end
                    end
                end
                ACK_DEV: begin
                    if (scl_fall) begin
                        if (rw) begin
                            tx_load = 1'b1;
                        end else begin
                            state_nx  = WORDADDR;
                            sda_oe_nx = 1'b0;
                        end
                    end
                end
                ACK_WORD: begin
                    if (scl_fall) begin
                        state_nx  = WAIT_STOP;
                        sda_oe_nx = 1'b0;
                    end
                end
                TX_BYTE: begin
                    if (scl_fall) begin
                        if (bit_cnt == 4'd7) begin
                            state_nx   = RX_ACK;
                            sda_oe_nx  = 1'b0;
                            bit_cnt_nx = 4'd0;
                        end else begin
                            shift_nx   = {shift[6:0], 1'b0};
                            sda_oe_nx  = ~shift[6];
                            bit_cnt_nx = bit_cnt + 4'd1;
                        end
                    end
                end
                RX_ACK: begin
                    // Entered on a fall, so the first fall seen here follows an ACK'd rise.
                    if (scl_rise && sda_s) begin
                        state_nx = WAIT_STOP;
                    end else if (scl_fall) begin
                        tx_load = 1'b1;
                    end
                end
                WAIT_STOP: sda_oe_nx = 1'b0;
                default: begin
                    state_nx  = IDLE;
                    sda_oe_nx = 1'b0;
                end
            endcase
        end
        if (tx_load) begin
            state_nx   = TX_BYTE;
            shift_nx   = rom_dout;
            ptr_nx     = ptr + 8'd1;
            sda_oe_nx  = ~rom_dout[7];
            bit_cnt_nx = 4'd0;
        end
    end

endmodule

// File: tb/tb_edid_i2c_target.sv
// Directed bench for edid_i2c_target; the ROM model returns addr ^ 8'hC3.
module tb_edid_i2c_target;

    localparam int Q = 8;
    localparam int H = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_in;
    logic       sda_m;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rom_addr;
    logic [7:0] rom_dout = 8'h00;
    logic       busy;

    int tests = 0;
    int fails = 0;
    logic watch_oe = 1'b0;
    logic saw_oe   = 1'b0;

    edid_i2c_target #(.DEV_ADDR(7'h50), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .sda_oe(sda_oe), .rom_addr(rom_addr), .rom_dout(rom_dout), .busy(busy)
    );

    always #5 clk = ~clk;

    assign sda_in = sda_m & ~sda_oe;

    // ROM with one-clock read latency.
    always @(posedge clk) rom_dout <= rom_addr ^ 8'hC3;

    always @(negedge clk) if (watch_oe && sda_oe) saw_oe = 1'b1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; clk_wait(Q);
        scl_in = 1'b1; clk_wait(Q);
        sda_m = 1'b0; clk_wait(Q);
        scl_in = 1'b0; clk_wait(Q);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; clk_wait(Q);
        scl_in = 1'b1; clk_wait(Q);
        sda_m = 1'b1; clk_wait(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic acked);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; clk_wait(Q);
            scl_in = 1'b1; clk_wait(H);
            scl_in = 1'b0; clk_wait(Q);
        end
        sda_m = 1'b1; clk_wait(Q);
        scl_in = 1'b1; clk_wait(H/2);
        acked = (sda_in == 1'b0);
        clk_wait(H/2);
        scl_in = 1'b0; clk_wait(Q);
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        d = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            clk_wait(Q);
            scl_in = 1'b1; clk_wait(H/2);
            d[i] = sda_in;
            clk_wait(H/2);
            scl_in = 1'b0; clk_wait(Q);
        end
        sda_m = ack ? 1'b0 : 1'b1; clk_wait(Q);
        scl_in = 1'b1; clk_wait(H);
        scl_in = 1'b0; clk_wait(Q);
        sda_m = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; scl_in = 1'b1; sda_m = 1'b1;
        clk_wait(3);
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        tests++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL reset_rom_addr: got %h want 00", rom_addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst_n = 1'b1;
        clk_wait(5);
    endtask

    task automatic test_read_after_reset;
        logic a; logic [7:0] d;
        i2c_start;
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rd0_busy_start: got %b want 1", busy); end
        write_byte(8'hA1, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL rd0_dev_ack: got %b want 1", a); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hC3) begin fails++; $display("FAIL rd0_byte0: got %h want c3", d); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'hC2) begin fails++; $display("FAIL rd0_byte1: got %h want c2", d); end
        i2c_stop;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rd0_busy_stop: got %b want 0", busy); end
        tests++; if (rom_addr !== 8'h02) begin fails++; $display("FAIL rd0_rom_addr: got %h want 02", rom_addr); end
    endtask

    task automatic test_random_read;
        logic a; logic [7:0] d;
        i2c_start;
        write_byte(8'hA0, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL rr_dev_w_ack: got %b want 1", a); end
        write_byte(8'h10, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL rr_word_ack: got %b want 1", a); end
        i2c_start;
        write_byte(8'hA1, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL rr_dev_r_ack: got %b want 1", a); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hD3) begin fails++; $display("FAIL rr_byte0: got %h want d3", d); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hD2) begin fails++; $display("FAIL rr_byte1: got %h want d2", d); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'hD1) begin fails++; $display("FAIL rr_byte2: got %h want d1", d); end
        i2c_stop;
        tests++; if (rom_addr !== 8'h13) begin fails++; $display("FAIL rr_rom_addr: got %h want 13", rom_addr); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_busy_stop: got %b want 0", busy); end
    endtask

    task automatic test_wrap;
        logic a; logic [7:0] d;
        i2c_start;
        write_byte(8'hA0, a);
        write_byte(8'hFE, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL wrap_word_ack: got %b want 1", a); end
        i2c_start;
        write_byte(8'hA1, a);
        read_byte(1'b1, d);
        tests++; if (d !== 8'h3D) begin fails++; $display("FAIL wrap_fe: got %h want 3d", d); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'h3C) begin fails++; $display("FAIL wrap_ff: got %h want 3c", d); end
        read_byte(1'b1, d);
        tests++; if (d !== 8'hC3) begin fails++; $display("FAIL wrap_00: got %h want c3", d); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'hC2) begin fails++; $display("FAIL wrap_01: got %h want c2", d); end
        i2c_stop;
        tests++; if (rom_addr !== 8'h02) begin fails++; $display("FAIL wrap_rom_addr: got %h want 02", rom_addr); end
    endtask

    task automatic test_wrong_addr;
        logic a;
        saw_oe = 1'b0; watch_oe = 1'b1;
        i2c_start;
        write_byte(8'hA2, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL bad_dev_ack: got %b want 0", a); end
        write_byte(8'h00, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL bad_data_ack: got %b want 0", a); end
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL bad_busy_before_stop: got %b want 1", busy); end
        i2c_stop;
        watch_oe = 1'b0;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL bad_busy_after_stop: got %b want 0", busy); end
        tests++; if (saw_oe !== 1'b0) begin fails++; $display("FAIL bad_sda_oe_seen: got %b want 0", saw_oe); end
    endtask

    task automatic test_write_nack;
        logic a; logic [7:0] d;
        i2c_start;
        write_byte(8'hA0, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL wr_dev_ack: got %b want 1", a); end
        write_byte(8'h20, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL wr_word_ack: got %b want 1", a); end
        write_byte(8'h55, a);
        tests++; if (a !== 1'b0) begin fails++; $display("FAIL wr_data_nack: got %b want 0", a); end
        i2c_stop;
        i2c_start;
        write_byte(8'hA1, a);
        read_byte(1'b0, d);
        tests++; if (d !== 8'hE3) begin fails++; $display("FAIL wr_readback: got %h want e3", d); end
        i2c_stop;
        tests++; if (rom_addr !== 8'h21) begin fails++; $display("FAIL wr_rom_addr: got %h want 21", rom_addr); end
    endtask

    task automatic test_reset_mid_tx;
        logic a; logic [7:0] d;
        i2c_start;
        write_byte(8'hA1, a);
        // ROM[0x21] = e2; its 4th bit (bit 4) is 0, so the target is pulling SDA low.
        for (int i = 0; i < 3; i++) begin
            clk_wait(Q);
            scl_in = 1'b1; clk_wait(H);
            scl_in = 1'b0; clk_wait(Q);
        end
        clk_wait(Q);
        scl_in = 1'b1; clk_wait(H/2);
        tests++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rst_mid_driving: got %b want 1", sda_oe); end
        rst_n = 1'b0;
        #1;
        tests++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_release: got %b want 0", sda_oe); end
        tests++; if (rom_addr !== 8'h00) begin fails++; $display("FAIL rst_mid_rom_addr: got %h want 00", rom_addr); end
        clk_wait(2);
        rst_n = 1'b1;
        clk_wait(4);
        saw_oe = 1'b0; watch_oe = 1'b1;
        scl_in = 1'b0; clk_wait(Q);
        for (int i = 0; i < 5; i++) begin
            clk_wait(Q);
            scl_in = 1'b1; clk_wait(H);
            scl_in = 1'b0; clk_wait(Q);
        end
        watch_oe = 1'b0;
        tests++; if (saw_oe !== 1'b0) begin fails++; $display("FAIL rst_mid_ignore_bus: got %b want 0", saw_oe); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
        i2c_stop;
        i2c_start;
        write_byte(8'hA1, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL rst_mid_dev_ack: got %b want 1", a); end
        read_byte(1'b0, d);
        tests++; if (d !== 8'hC3) begin fails++; $display("FAIL rst_mid_byte0: got %h want c3", d); end
        i2c_stop;
        tests++; if (rom_addr !== 8'h01) begin fails++; $display("FAIL rst_mid_rom_addr_after: got %h want 01", rom_addr); end
    endtask

    initial begin
        test_reset;
        test_read_after_reset;
        test_random_read;
        test_wrap;
        test_wrong_addr;
        test_write_nack;
        test_reset_mid_tx;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
